// File: rtl/rr_req_sched_pkg.sv
// Shared types and width helpers for the round-robin request scheduler.
package rr_req_sched_pkg;

  // Scheduler FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } state_e;

  localparam int DEF_N_CLIENTS = 4;
  localparam int DEF_MAX_HOLD  = 8;
  localparam int DEF_TIMEOUT   = 16;

  // Width of a client index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width: one spare bit above the larger limit so saturation is never reached in use.
  function automatic int cnt_width(input int max_hold, input int timeout);
    return $clog2((max_hold > timeout) ? max_hold : timeout) + 1;
  endfunction

endpackage

// File: rtl/rr_req_sched_pick.sv
// Rotate-priority picker: first set request bit at or after ptr, wrapping.
module rr_req_sched_pick
  import rr_req_sched_pkg::*;
#(
  parameter int N_CLIENTS = DEF_N_CLIENTS
) (
  input  logic [N_CLIENTS-1:0]           req,
  input  logic [id_width(N_CLIENTS)-1:0] ptr,
  output logic                           valid,
  output logic [id_width(N_CLIENTS)-1:0] idx
);

  localparam int              ID_W  = id_width(N_CLIENTS);
  localparam logic [ID_W:0]   N_EXT = (ID_W+1)'(N_CLIENTS);

  logic [N_CLIENTS-1:0] rot;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        sum;

  // Rotate so that bit 0 of rot corresponds to client ptr.
  assign rot = N_CLIENTS'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the next client in round-robin order.
  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = ID_W'(i);
      end
    end
  end

  // Undo the rotation: idx = (ptr + off) mod N_CLIENTS.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_EXT) begin
      idx = ID_W'(sum - N_EXT);
    end else begin
      idx = sum[ID_W-1:0];
    end
  end

endmodule

// File: rtl/rr_req_sched.sv
// Round-robin request scheduler in front of a single-line request/grant arbiter.
// Picks one requesting client, requests the arbiter, hands the grant to that
// client for a bounded time, then releases and advances the round-robin pointer.
module rr_req_sched
  import rr_req_sched_pkg::*;
#(
  parameter int N_CLIENTS = DEF_N_CLIENTS,
  parameter int MAX_HOLD  = DEF_MAX_HOLD,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_CLIENTS-1:0]           cli_req,
  output logic [N_CLIENTS-1:0]           cli_gnt,
  output logic [id_width(N_CLIENTS)-1:0] cur_id,
  output logic                           busy,
  output logic                           arb_request,
  input  logic                           arb_grant,
  output logic                           err_timeout,
  output logic                           err_lost
);

  localparam int                   ID_W      = id_width(N_CLIENTS);
  localparam int                   CNT_W     = cnt_width(MAX_HOLD, TIMEOUT);
  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0]     WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]      ID_LAST   = ID_W'(N_CLIENTS - 1);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0  = N_CLIENTS'(1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N_CLIENTS-1:0] cli_gnt_q, cli_gnt_d;
  logic                 arb_request_q, arb_request_d;
  logic                 busy_q, busy_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_lost_q, err_lost_d;

  logic                 pick_valid;
  logic [ID_W-1:0]      pick_idx;

  rr_req_sched_pick #(
    .N_CLIENTS (N_CLIENTS)
  ) u_pick (
    .req   (cli_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic; every output is a registered copy of its _d.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_id_d      = cur_id_q;
    wait_cnt_d    = wait_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    cli_gnt_d     = cli_gnt_q;
    arb_request_d = arb_request_q;
    err_timeout_d = 1'b0;
    err_lost_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cli_gnt_d     = '0;
        arb_request_d = 1'b0;
        if (pick_valid) begin
          cur_id_d      = pick_idx;
          arb_request_d = 1'b1;
          wait_cnt_d    = '0;
          state_d       = REQ;
        end
      end

      REQ: begin
        if (arb_grant) begin
          cli_gnt_d  = ONE_HOT0 << cur_id_q;
          hold_cnt_d = '0;
          state_d    = OWN;
        end else if (!cli_req[cur_id_q]) begin
          arb_request_d = 1'b0;
          state_d       = REL;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_timeout_d = 1'b1;
          arb_request_d = 1'b0;
          state_d       = REL;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      OWN: begin
        // A lost grant is reported even if the client is also letting go.
        if (!arb_grant) begin
          err_lost_d    = 1'b1;
          cli_gnt_d     = '0;
          arb_request_d = 1'b0;
          state_d       = REL;
        end else if (!cli_req[cur_id_q] || (hold_cnt_q == HOLD_LAST)) begin
          cli_gnt_d     = '0;
          arb_request_d = 1'b0;
          state_d       = REL;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      REL: begin
        cli_gnt_d     = '0;
        arb_request_d = 1'b0;
        // Pointer moves past the client just handled, whether served or aborted.
        if (!arb_grant) begin
          ptr_d   = (cur_id_q == ID_LAST) ? '0 : cur_id_q + ID_W'(1);
          state_d = IDLE;
        end
      end

      default: begin
        cli_gnt_d     = '0;
        arb_request_d = 1'b0;
        state_d       = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, pointer, counters and output registers; async reset clears all at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cur_id_q      <= '0;
      wait_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      cli_gnt_q     <= '0;
      arb_request_q <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_lost_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_id_q      <= cur_id_d;
      wait_cnt_q    <= wait_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      cli_gnt_q     <= cli_gnt_d;
      arb_request_q <= arb_request_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_lost_q    <= err_lost_d;
    end
  end

  assign cli_gnt     = cli_gnt_q;
  assign cur_id      = cur_id_q;
  assign busy        = busy_q;
  assign arb_request = arb_request_q;
  assign err_timeout = err_timeout_q;
  assign err_lost    = err_lost_q;

endmodule

// File: tb/tb_rr_req_sched.sv
// Bench for rr_req_sched with a behavioural 1-cycle arbiter and a scoreboard.
module tb_rr_req_sched;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int TIMEOUT  = 16;

  localparam int K_GRANT   = 0;
  localparam int K_LOST    = 1;
  localparam int K_TIMEOUT = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] cli_req = '0;
  logic [N-1:0] cli_gnt;
  logic [1:0]   cur_id;
  logic         busy, arb_request, arb_grant, err_timeout, err_lost;
  logic         arb_q;
  logic         arb_kill = 1'b0;

  always #10 clk = ~clk;

  // Arbiter stand-in: grant follows request one cycle later; arb_kill forces it low.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) arb_q <= 1'b0;
    else          arb_q <= arb_request;
  end
  assign arb_grant = arb_q & ~arb_kill;

  rr_req_sched #(.N_CLIENTS(N), .MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cli_req     (cli_req),
    .cli_gnt     (cli_gnt),
    .cur_id      (cur_id),
    .busy        (busy),
    .arb_request (arb_request),
    .arb_grant   (arb_grant),
    .err_timeout (err_timeout),
    .err_lost    (err_lost)
  );

  typedef struct {
    int kind;
    int id;
    int dur;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  int   model_ptr = 0;
  int   len[N];
  int   cnt[N];
  bit   sticky = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: next client walking the circle from p.
  function automatic int next_from(input logic [N-1:0] mask, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic push(input int kind, input int id, input int dur);
    exp_t e;
    e.kind = kind;
    e.id   = id;
    e.dur  = dur;
    exp_q.push_back(e);
  endtask

  // Raise a set of requests at once; each client is served once for min(len, MAX_HOLD).
  task automatic issue_batch(input logic [N-1:0] mask);
    logic [N-1:0] left;
    int id;
    left = mask;
    while (left != '0) begin
      id = next_from(left, model_ptr);
      push(K_GRANT, id, (len[id] < MAX_HOLD) ? len[id] : MAX_HOLD);
      left[id] = 1'b0;
      model_ptr = (id + 1) % N;
    end
    for (int i = 0; i < N; i++) if (mask[i]) cnt[i] = 0;
    cli_req = cli_req | mask;
  endtask

  // One cycle of client behaviour: drop the request after len granted cycles or when the grant ends.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (cli_req[i] && !sticky) begin
        if (cli_gnt[i]) begin
          cnt[i]++;
          if (cnt[i] >= len[i]) cli_req[i] = 1'b0;
        end else if (cnt[i] > 0) begin
          cli_req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int target;
    int b;
    target = pops + exp_q.size();
    b = budget;
    while (pops < target && b > 0) begin
      tick();
      b--;
    end
    check(name, pops, target);
  endtask

  task automatic wait_cnt(input int id, input int n, input string name);
    int b;
    b = 100;
    while (cnt[id] < n && b > 0) begin
      tick();
      b--;
    end
    check(name, cnt[id], n);
  endtask

  // Monitor: compares each completed grant episode and each error pulse against the queue.
  int in_ep = 0, ep_id = 0, ep_len = 0, req_len = 0, low_seen = 1;
  initial begin
    exp_t e;
    int   id;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        in_ep = 0;
        req_len = 0;
        low_seen = 1;
      end else begin
        checks++;
        if ($countones(cli_gnt) > 1 || (cli_gnt != '0 && !(arb_request && busy))) begin
          errors++;
          $display("FAIL gnt_invariant: cli_gnt=%b arb_request=%b busy=%b", cli_gnt, arb_request, busy);
        end
        if (err_lost && !(cli_gnt == '0 && in_ep != 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_lost: err_lost=1 outside an ending grant");
        end
        if (err_timeout) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_timeout: err_timeout=1 with nothing expected");
          end else begin
            e = exp_q.pop_front();
            pops++;
            check("timeout_kind", K_TIMEOUT, e.kind);
            check("timeout_id", int'(cur_id), e.id);
            check("timeout_wait", req_len, e.dur);
            check("timeout_gnt", int'(cli_gnt), 0);
          end
        end
        if (cli_gnt != '0) begin
          id = 0;
          for (int i = 0; i < N; i++) if (cli_gnt[i]) id = i;
          if (in_ep == 0) begin
            check("gap_before_grant", low_seen, 1);
            in_ep = 1;
            ep_id = id;
            ep_len = 1;
            low_seen = 0;
          end else begin
            ep_len++;
            check("gnt_stable", id, ep_id);
          end
        end else if (in_ep != 0) begin
          in_ep = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: client %0d held %0d cycles, nothing expected", ep_id, ep_len);
          end else begin
            e = exp_q.pop_front();
            pops++;
            check("grant_kind", err_lost ? K_LOST : K_GRANT, e.kind);
            check("grant_id", ep_id, e.id);
            if (e.dur >= 0) check("grant_len", ep_len, e.dur);
            check("rel_arb_request", int'(arb_request), 0);
          end
        end
        if (arb_request) begin
          req_len++;
        end else begin
          req_len = 0;
          low_seen = 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int id;
    for (int i = 0; i < N; i++) begin
      len[i] = 1;
      cnt[i] = 0;
    end

    // Reset with all clients requesting.
    reset_n = 1'b0;
    cli_req = 4'b1111;
    sticky  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_cli_gnt", int'(cli_gnt), 0);
    check("rst_cur_id", int'(cur_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_arb_request", int'(arb_request), 0);
    check("rst_err_timeout", int'(err_timeout), 0);
    check("rst_err_lost", int'(err_lost), 0);

    // Rotation with everybody holding: five grants of MAX_HOLD cycles each.
    for (int k = 0; k < 5; k++) begin
      id = next_from(4'b1111, model_ptr);
      push(K_GRANT, id, MAX_HOLD);
      model_ptr = (id + 1) % N;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_arb_request", int'(arb_request), 1);
    check("first_gnt_k", int'(cli_gnt), 0);
    @(posedge clk); #1;
    check("first_gnt_k1", int'(cli_gnt), 0);
    @(posedge clk); #1;
    check("first_gnt_k2", int'(cli_gnt), 1);
    wait_drain(400, "rotation_done");
    cli_req = '0;
    sticky  = 1'b0;
    idle(6);
    check("rotation_idle", int'(busy), 0);

    // Early release by client 2, then 1001 continues from client 3.
    len[2] = 3;
    issue_batch(4'b0100);
    wait_drain(100, "early_release_done");
    idle(2);
    len[0] = 2;
    len[3] = 2;
    issue_batch(4'b1001);
    wait_drain(100, "after_early_done");
    idle(4);

    // Timeout: arbiter never grants.
    arb_kill = 1'b1;
    sticky   = 1'b1;
    push(K_TIMEOUT, 0, TIMEOUT);
    model_ptr = 1;
    cli_req = 4'b0001;
    wait_drain(100, "timeout_done");
    cli_req = '0;
    sticky  = 1'b0;
    idle(4);
    check("timeout_idle", int'(busy), 0);
    arb_kill = 1'b0;
    idle(2);

    // Lost grant during ownership.
    len[1] = 99;
    cnt[1] = 0;
    push(K_LOST, 1, -1);
    model_ptr = 2;
    cli_req[1] = 1'b1;
    wait_cnt(1, 3, "lost_owned");
    arb_kill = 1'b1;
    tick();
    arb_kill = 1'b0;
    wait_drain(50, "lost_done");
    idle(4);
    check("lost_idle", int'(busy), 0);

    // Async reset in the middle of ownership.
    len[2] = 99;
    cnt[2] = 0;
    cli_req[2] = 1'b1;
    wait_cnt(2, 2, "areset_owned");
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_cli_gnt", int'(cli_gnt), 0);
    check("areset_arb_request", int'(arb_request), 0);
    check("areset_busy", int'(busy), 0);
    model_ptr = 0;
    cli_req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    len[0] = 3;
    len[2] = 5;
    len[3] = 12;
    issue_batch(4'b1101);
    wait_drain(200, "areset_after_done");
    idle(3);

    // Random batches against the rotation model.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++) len[i] = $urandom_range(1, 12);
      issue_batch(4'($urandom_range(1, 15)));
      wait_drain(400, "random_batch_done");
      idle($urandom_range(1, 3));
    end

    idle(4);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
